// File: rtl/dft_wb_host.sv
// dft_wb_host: Wishbone master that sequences the 32-point DFT peripheral.
// Loads samples from a local buffer, kicks the transform, polls data_valid,
// then copies the results into a local result buffer.
// Optional poll watchdog: define DFT_HOST_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for start_i
// FETCH     | sample buffer address presented
// W_ADDR    | write dataW_addr <- i (sample captured here)
// W_LO      | write data lo
// W_HI      | write data hi
// W_SET     | write dataW <- 1
// W_CLR     | write dataW <- 0, advance sample index
// NEXT_SET  | write next <- 1
// NEXT_CLR  | write next <- 0
// POLL      | read data_valid
// POLL_WAIT | idle gap between polls
// DRAIN     | let the peripheral finish result capture
// R_ADDR    | write dataR_addr <- j
// R_LO      | read result lo
// R_HI      | read result hi
// STORE     | write result j into the result buffer
// DONE      | completion pulse
// ERR       | bus error / watchdog abort pulse
module dft_wb_host #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned N_POINTS     = 32,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned DRAIN_CYCLES = 40,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [5:0]  in_addr_o,
  input  logic [63:0] in_data_i,
  output logic        out_we_o,
  output logic [5:0]  out_addr_o,
  output logic [63:0] out_data_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [4:0] {
    IDLE, FETCH, W_ADDR, W_LO, W_HI, W_SET, W_CLR, NEXT_SET, NEXT_CLR,
    POLL, POLL_WAIT, DRAIN, R_ADDR, R_LO, R_HI, STORE, DONE, ERR
  } state_t;

  localparam logic [5:0]  LAST_IDX   = 6'(N_POINTS - 1);
  localparam logic [15:0] GAP_LOAD   = 16'(POLL_GAP - 1);
  localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic        gap_q;
  logic [5:0]  idx_q;
  logic [15:0] wait_q;
  logic [63:0] sample_q;
  logic [31:0] lo_q, hi_q;
  logic        err_q;
  logic        bus_req, bus_we, bus_act, poll_timeout;
  logic [7:0]  bus_off;
  logic [31:0] bus_dat;

`ifdef DFT_HOST_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT);
  logic [15:0] poll_left_q;

  // Remaining poll reads before the peripheral is declared hung.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)
      poll_left_q <= '0;
    else if (state_q == NEXT_CLR)
      poll_left_q <= TIMEOUT_LOAD;
    else if (state_q == POLL && bus_act && wbm_ack_i && !wbm_dat_i[0] && poll_left_q != 16'd0)
      poll_left_q <= poll_left_q - 16'd1;
  end

  assign poll_timeout = (poll_left_q == 16'd1);
`else
  // Without the watchdog TIMEOUT has no effect and polling never gives up.
  assign poll_timeout = (TIMEOUT == 0) & 1'b0;
`endif

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state and bus request; each access is active until ack, then one gap cycle.
  always_comb begin
    state_d = state_q;
    bus_req = 1'b0;
    bus_we  = 1'b0;
    bus_off = 8'h00;
    bus_dat = 32'h0;
    unique case (state_q)
      IDLE:      if (start_i) state_d = FETCH;
      FETCH:     state_d = W_ADDR;
      W_ADDR: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_off = 8'h08; bus_dat = {26'd0, idx_q};
        if (gap_q) state_d = W_LO;
      end
      W_LO: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_off = 8'h0C; bus_dat = sample_q[31:0];
        if (gap_q) state_d = W_HI;
      end
      W_HI: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_off = 8'h10; bus_dat = sample_q[63:32];
        if (gap_q) state_d = W_SET;
      end
      W_SET: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_off = 8'h04; bus_dat = 32'd1;
        if (gap_q) state_d = W_CLR;
      end
      W_CLR: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_off = 8'h04; bus_dat = 32'd0;
        if (gap_q) state_d = (idx_q == LAST_IDX) ? NEXT_SET : FETCH;
      end
      NEXT_SET: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_off = 8'h00; bus_dat = 32'd1;
        if (gap_q) state_d = NEXT_CLR;
      end
      NEXT_CLR: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_off = 8'h00; bus_dat = 32'd0;
        if (gap_q) state_d = POLL;
      end
      POLL: begin
        bus_req = 1'b1; bus_off = 8'h14;
        // The following wait/drain state doubles as the inter-access idle cycle.
        if (wbm_ack_i) begin
          if (wbm_dat_i[0])      state_d = DRAIN;
          else if (poll_timeout) state_d = ERR;
          else                   state_d = POLL_WAIT;
        end
      end
      POLL_WAIT: if (wait_q == 16'd0) state_d = POLL;
      DRAIN:     if (wait_q == 16'd0) state_d = R_ADDR;
      R_ADDR: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_off = 8'h14; bus_dat = {26'd0, idx_q};
        if (gap_q) state_d = R_LO;
      end
      R_LO: begin
        bus_req = 1'b1; bus_off = 8'h20;
        if (gap_q) state_d = R_HI;
      end
      R_HI: begin
        bus_req = 1'b1; bus_off = 8'h24;
        if (gap_q) state_d = STORE;
      end
      STORE:     state_d = (idx_q == LAST_IDX) ? DONE : R_ADDR;
      DONE:      state_d = IDLE;
      ERR:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    bus_act = bus_req & ~gap_q;
    // err wins over ack; no further access is issued after it.
    if (bus_act && wbm_err_i) state_d = ERR;
  end

  // Datapath: gap flag, indices, captured sample/result words, wait timer, error flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      gap_q    <= 1'b0;
      idx_q    <= '0;
      wait_q   <= '0;
      sample_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      gap_q <= bus_act && wbm_ack_i && !wbm_err_i && (state_q != POLL);

      if (state_q == IDLE && start_i)
        idx_q <= '0;
      else if ((state_q == W_CLR && gap_q) || state_q == STORE)
        idx_q <= (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;

      if (state_q == W_ADDR) sample_q <= in_data_i;
      if (state_q == R_LO && bus_act && wbm_ack_i) lo_q <= wbm_dat_i;
      if (state_q == R_HI && bus_act && wbm_ack_i) hi_q <= wbm_dat_i;

      if (state_q == POLL && state_d == POLL_WAIT)  wait_q <= GAP_LOAD;
      else if (state_q == POLL && state_d == DRAIN) wait_q <= DRAIN_LOAD;
      else if (wait_q != 16'd0)                     wait_q <= wait_q - 16'd1;

      if (state_q == IDLE && start_i) err_q <= 1'b0;
      else if (state_d == ERR)        err_q <= 1'b1;
    end
  end

  assign wbm_cyc_o  = bus_act;
  assign wbm_stb_o  = bus_act;
  assign wbm_we_o   = bus_act & bus_we;
  assign wbm_adr_o  = bus_act ? (BASE_ADDR + {24'd0, bus_off}) : 32'h0;
  assign wbm_dat_o  = (bus_act & bus_we) ? bus_dat : 32'h0;
  assign wbm_sel_o  = 4'hF;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE) || (state_q == ERR);
  assign err_o      = err_q;
  assign in_addr_o  = idx_q;
  assign out_we_o   = (state_q == STORE);
  assign out_addr_o = out_we_o ? idx_q : 6'd0;
  assign out_data_o = out_we_o ? {hi_q, lo_q} : 64'h0;

endmodule

// File: tb/tb_dft_wb_host.sv
// Bench for dft_wb_host: behavioural DFT peripheral on the bus, sample RAM,
// result scoreboard and bus access log.
module tb_dft_wb_host;
  localparam int N = 32;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int VALID_LAT = 12;
`ifdef DFT_HOST_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 4096;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, err_flag, out_we, cyc, stb, we, ack, berr;
  logic [5:0] in_addr, out_addr;
  logic [63:0] in_data = '0, out_data;
  logic [31:0] adr, dat, rdat;
  logic [3:0] sel;

  always #5 clk = ~clk;

  dft_wb_host #(.BASE_ADDR(BASE), .N_POINTS(N), .POLL_GAP(4), .DRAIN_CYCLES(40), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err_flag),
    .in_addr_o(in_addr), .in_data_i(in_data), .out_we_o(out_we), .out_addr_o(out_addr), .out_data_o(out_data),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_dat_i(rdat), .wbm_ack_i(ack), .wbm_err_i(berr));

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] xform(input logic [63:0] x, input int k);
    return x ^ (64'h0123_4567_89AB_CDEF * 64'(k + 1));
  endfunction

  // sample buffer, 1-cycle read latency
  logic [63:0] mem [N];
  always @(posedge clk) in_data <= mem[in_addr];

  // DFT peripheral model
  int ack_dly = 0, err_at = 0, acc_n = 0, wcnt = 0, p_cnt = 0, cyc_n = 0;
  bit valid_never = 0;
  logic p_valid = 1'b0, p_run = 1'b0;
  logic [5:0] p_waddr = '0, p_raddr = '0;
  logic [31:0] p_lo = '0, p_hi = '0, off;
  logic [63:0] p_samp [N];
  logic [63:0] p_res [N];
  logic hit;

  assign off  = adr - BASE;
  assign hit  = cyc && stb && (wcnt == ack_dly);
  assign berr = hit && (err_at != 0) && (acc_n + 1 == err_at);
  assign ack  = hit && !berr;

  always_comb begin
    rdat = 32'hDEAD_BEEF;
    case (off)
      32'h14: rdat = {31'd0, p_valid};
      32'h20: rdat = p_res[p_raddr][31:0];
      32'h24: rdat = p_res[p_raddr][63:32];
      default: rdat = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk) begin
    cyc_n++;
    if (cyc && stb && !(ack || berr)) wcnt <= wcnt + 1; else wcnt <= 0;
    if (ack || berr) acc_n <= acc_n + 1;
    if (p_cnt > 0) begin
      p_cnt <= p_cnt - 1;
      if (p_cnt == 1 && !valid_never) begin
        p_valid <= 1'b1;
        for (int k = 0; k < N; k++) p_res[k] <= xform(p_samp[(k * 7) % N], k);
      end
    end
    if (ack && we) begin
      case (off)
        32'h08: p_waddr <= dat[5:0];
        32'h0C: p_lo <= dat;
        32'h10: p_hi <= dat;
        32'h04: if (dat[0]) p_samp[p_waddr] <= {p_hi, p_lo};
        32'h00: if (dat[0]) begin p_valid <= 1'b0; p_run <= 1'b1; end
                else if (p_run) begin p_run <= 1'b0; p_cnt <= VALID_LAT; end
        32'h14: p_raddr <= dat[5:0];
        default: ;
      endcase
    end
  end

  // bus access log
  typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; logic [3:0] sel; int cn; int hold; } acc_t;
  acc_t log_q[$];
  int hold_cnt = 0, idle_viol = 0, unstable = 0;
  bit prev_term = 0, prev_stb = 0;
  logic [31:0] prev_adr = '0, prev_dat = '0;
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (stb) begin
      if (prev_term) idle_viol++;
      if (prev_stb && !prev_term && (adr != prev_adr || dat != prev_dat || we != prev_we)) unstable++;
      if (cyc != stb) unstable++;
      hold_cnt++;
    end
    if (stb && (ack || berr)) begin
      log_q.push_back('{adr, dat, we, sel, cyc_n, hold_cnt});
      hold_cnt = 0;
    end
    if (!stb) hold_cnt = 0;
    prev_term = stb && (ack || berr);
    prev_stb = stb; prev_adr = adr; prev_dat = dat; prev_we = we;
  end

  // result scoreboard
  typedef struct { logic [5:0] a; logic [63:0] d; } exp_t;
  exp_t sb_q[$];
  int n_we = 0;
  always @(negedge clk) begin
    if (out_we) begin
      n_we++;
      if (sb_q.size() == 0) check("sb_unexpected_write", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_addr", 64'(out_addr), 64'(e.a));
        check("res_data", out_data, e.d);
      end
    end
  end

  function automatic int n_polls();
    int n = 0;
    foreach (log_q[i]) if (!log_q[i].we && log_q[i].adr == BASE + 32'h14) n++;
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, done, err_flag, out_we, cyc, stb, we, sel}, {7'd0, 4'hF});
    check({tag, "_addrs"}, {in_addr, out_addr}, 12'd0);
    check({tag, "_out_data"}, out_data, 64'd0);
    check({tag, "_bus"}, {adr, dat}, 64'd0);
  endtask

  task automatic run_xform(input int dly, input int eat, input bit push_exp, input bit exp_done, input int max_cyc);
    bit got_done;
    got_done = 0;
    @(posedge clk); #1;
    ack_dly = dly;
    err_at = (eat > 0) ? acc_n + eat : 0;
    log_q.delete(); idle_viol = 0; unstable = 0;
    if (push_exp) for (int k = 0; k < N; k++) sb_q.push_back('{6'(k), xform(mem[(k * 7) % N], k)});
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check("start_busy", busy, 1);
    check("start_in_addr", in_addr, 0);
    check("start_err_clear", err_flag, 0);
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;              // must be ignored while busy
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < max_cyc && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    check("done_seen", got_done, exp_done);
    if (got_done) begin
      check("cyc_low_at_done", cyc, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
  endtask

  typedef struct { int dly; int eat; bit exp_err; int exp_we; int exp_nonpoll; bit chk_timing; } vec_t;

  task automatic apply_vec(input vec_t v, input string tag);
    int we0, hmin, hmax;
    int pidx[$];
    logic [7:0] eoff [5];
    logic [31:0] edat [5];
    we0 = n_we;
    run_xform(v.dly, v.eat, !v.exp_err, 1'b1, 20000);
    repeat (60) @(negedge clk);
    check({tag, "_err_o"}, err_flag, v.exp_err);
    check({tag, "_n_results"}, n_we - we0, v.exp_we);
    check({tag, "_nonpoll_acc"}, log_q.size() - n_polls(), v.exp_nonpoll);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
    check({tag, "_idle_gap_viol"}, idle_viol, 0);
    check({tag, "_unstable"}, unstable, 0);
    hmin = 1000; hmax = 0;
    foreach (log_q[i]) begin
      if (log_q[i].hold < hmin) hmin = log_q[i].hold;
      if (log_q[i].hold > hmax) hmax = log_q[i].hold;
    end
    check({tag, "_hold_min"}, hmin, v.dly + 1);
    check({tag, "_hold_max"}, hmax, v.dly + 1);
    if (v.chk_timing) begin
      check("order_log_len", log_q.size() >= 10, 1);
      for (int s = 0; s < 2 && log_q.size() >= 10; s++) begin
        eoff[0] = 8'h08; edat[0] = 32'(s);
        eoff[1] = 8'h0C; edat[1] = mem[s][31:0];
        eoff[2] = 8'h10; edat[2] = mem[s][63:32];
        eoff[3] = 8'h04; edat[3] = 32'd1;
        eoff[4] = 8'h04; edat[4] = 32'd0;
        for (int w = 0; w < 5; w++) begin
          check($sformatf("order%0d_adr_dat", s * 5 + w), {log_q[s * 5 + w].adr, log_q[s * 5 + w].dat},
                {BASE + {24'd0, eoff[w]}, edat[w]});
          check($sformatf("order%0d_we_sel", s * 5 + w), {log_q[s * 5 + w].we, log_q[s * 5 + w].sel}, 5'h1F);
        end
      end
      if (log_q.size() >= 6) check("load_cycles_per_sample", log_q[5].cn - log_q[0].cn, 11);
      foreach (log_q[i]) if (!log_q[i].we && log_q[i].adr == BASE + 32'h14) pidx.push_back(i);
      check("polls_seen", pidx.size() >= 2, 1);
      if (pidx.size() >= 2 && pidx[$] + 4 < log_q.size()) begin
        check("poll_spacing", log_q[pidx[1]].cn - log_q[pidx[0]].cn, 5);
        check("drain_spacing", log_q[pidx[$] + 1].cn - log_q[pidx[$]].cn, 41);
        check("read_cycles_per_result", log_q[pidx[$] + 4].cn - log_q[pidx[$] + 1].cn, 7);
      end
    end
  endtask

  vec_t vt[4];
  bit found;

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 64'(i) * 64'h0001_0001_0001_0001;
    vt[0] = '{0, 0,  1'b0, 32, 258, 1'b1};
    vt[1] = '{3, 0,  1'b0, 32, 258, 1'b0};
    vt[2] = '{0, 10, 1'b1, 0,  10,  1'b0};
    vt[3] = '{1, 0,  1'b0, 32, 258, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    // data_valid never rises
    valid_never = 1;
`ifdef DFT_HOST_TIMEOUT_EN
    run_xform(0, 0, 1'b0, 1'b1, 3000);
    check("timeout_poll_reads", n_polls(), TMO);
    check("timeout_err_o", err_flag, 1);
    check("timeout_nonpoll", log_q.size() - n_polls(), 162);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
`else
    run_xform(0, 0, 1'b0, 1'b0, 700);
    check("poll_forever_busy", busy, 1);
    check("poll_forever_err_o", err_flag, 0);
    check("poll_forever_reads", n_polls() >= 40, 1);
    check("poll_forever_nonpoll", log_q.size() - n_polls(), 162);
`endif

    // asynchronous reset in the middle of a poll read
    found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(posedge clk); #2;
      if (cyc && !we && adr == BASE + 32'h14) found = 1;
    end
    check("poll_read_reached", found, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    valid_never = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_vec(vt[0], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
